// File: rtl/logic_gates_bist_checker.sv
// Built-in self-test for the two-input logic gate unit: walks {a,b} through
// 00..11, compares the seven gate outputs to their truth table and logs errors.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | waiting for start, previous results held
// S_APPLY  | drive a/b from vec, load settle counter
// S_SETTLE | hold vector while gate outputs settle
// S_CHECK  | sample gate outputs, accumulate mismatches, advance vec
// S_FINISH | one-cycle done pulse, publish pass, park a/b at 0
module logic_gates_bist_checker #(
   parameter int SETTLE_CYCLES = 2,
   parameter int ERR_CNT_W     = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   output logic                 a_out,
   output logic                 b_out,
   input  logic                 and_in,
   input  logic                 or_in,
   input  logic                 not_in,
   input  logic                 nand_in,
   input  logic                 nor_in,
   input  logic                 xor_in,
   input  logic                 xnor_in,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [6:0]           err_mask,
   output logic [ERR_CNT_W-1:0] err_count,
   output logic [1:0]           fail_vec,
   output logic                 fail_valid
);

   localparam int CNT_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
   localparam int SUM_W = ERR_CNT_W + 3;
   localparam logic [CNT_W-1:0]     SETTLE_LD = CNT_W'(SETTLE_CYCLES);
   localparam logic [ERR_CNT_W-1:0] CNT_MAX   = '1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_APPLY,
      S_SETTLE,
      S_CHECK,
      S_FINISH
   } state_t;

   state_t           state;
   logic [1:0]       vec;
   logic [CNT_W-1:0] settle_cnt;

   logic [6:0]       exp_g;
   logic [6:0]       obs_g;
   logic [6:0]       mism;
   logic [2:0]       mis_cnt;
   logic [SUM_W-1:0] cnt_sum;
   logic [ERR_CNT_W-1:0] cnt_next;

   // Expected values derive from the registered a/b actually driven to the unit.
   always_comb begin
      exp_g[0] = a_out & b_out;
      exp_g[1] = a_out | b_out;
      exp_g[2] = ~a_out;
      exp_g[3] = ~(a_out & b_out);
      exp_g[4] = ~(a_out | b_out);
      exp_g[5] = a_out ^ b_out;
      exp_g[6] = ~(a_out ^ b_out);
      obs_g    = {xnor_in, xor_in, nor_in, nand_in, not_in, or_in, and_in};
      mism     = obs_g ^ exp_g;
      mis_cnt  = 3'd0;
      for (int i = 0; i < 7; i++) begin
         mis_cnt = mis_cnt + {2'b00, mism[i]};
      end
      cnt_sum  = {3'b000, err_count} + SUM_W'(mis_cnt);
      cnt_next = (cnt_sum > {3'b000, CNT_MAX}) ? CNT_MAX : cnt_sum[ERR_CNT_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         vec        <= 2'd0;
         settle_cnt <= '0;
         a_out      <= 1'b0;
         b_out      <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         err_mask   <= 7'd0;
         err_count  <= '0;
         fail_vec   <= 2'd0;
         fail_valid <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  err_mask   <= 7'd0;
                  err_count  <= '0;
                  fail_valid <= 1'b0;
                  fail_vec   <= 2'd0;
                  pass       <= 1'b0;
                  vec        <= 2'd0;
                  busy       <= 1'b1;
                  state      <= S_APPLY;
               end
            end
            S_APPLY: begin
               a_out      <= vec[1];
               b_out      <= vec[0];
               settle_cnt <= SETTLE_LD;
               state      <= (SETTLE_CYCLES > 0) ? S_SETTLE : S_CHECK;
            end
            S_SETTLE: begin
               settle_cnt <= settle_cnt - CNT_W'(1);
               if (settle_cnt == CNT_W'(1)) state <= S_CHECK;
            end
            S_CHECK: begin
               err_mask  <= err_mask | mism;
               err_count <= cnt_next;
               if ((mism != 7'd0) && !fail_valid) begin
                  fail_vec   <= vec;
                  fail_valid <= 1'b1;
               end
               if (vec == 2'd3) begin
                  state <= S_FINISH;
               end else begin
                  vec   <= vec + 2'd1;
                  state <= S_APPLY;
               end
            end
            S_FINISH: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               pass  <= (err_mask == 7'd0);
               a_out <= 1'b0;
               b_out <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_logic_gates_bist_checker.sv
// Bench for logic_gates_bist_checker: three configurations driven against a
// fault-injectable gate unit model, results checked against a truth-table model.
module tb_logic_gates_bist_checker;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [2:0] rst, start, a_o, b_o, busy, done, pass, fvld;
   logic [6:0] em [3];
   logic [1:0] fv [3];
   logic [4:0] ec [3];
   logic [4:0] ec0, ec2;
   logic [1:0] ec1;
   logic [6:0] gi [3];
   logic [6:0] inv [3];
   logic [6:0] stk [3];

   int checks   = 0;
   int failures = 0;

   assign ec[0] = ec0;
   assign ec[1] = {3'b000, ec1};
   assign ec[2] = ec2;

   // Gate unit under test: golden gates with per-output invert and stuck-at-0 faults.
   for (genvar g = 0; g < 3; g++) begin : g_unit
      logic a, b;
      logic [6:0] gold;
      assign a    = a_o[g];
      assign b    = b_o[g];
      assign gold = {~(a ^ b), a ^ b, ~(a | b), ~(a & b), ~a, a | b, a & b};
      assign gi[g] = (gold ^ inv[g]) & ~stk[g];
   end

   logic_gates_bist_checker #(.SETTLE_CYCLES(2), .ERR_CNT_W(5)) u_dut0 (
      .clk(clk), .rst(rst[0]), .start(start[0]), .a_out(a_o[0]), .b_out(b_o[0]),
      .and_in(gi[0][0]), .or_in(gi[0][1]), .not_in(gi[0][2]), .nand_in(gi[0][3]),
      .nor_in(gi[0][4]), .xor_in(gi[0][5]), .xnor_in(gi[0][6]),
      .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_mask(em[0]),
      .err_count(ec0), .fail_vec(fv[0]), .fail_valid(fvld[0]));

   logic_gates_bist_checker #(.SETTLE_CYCLES(2), .ERR_CNT_W(2)) u_dut1 (
      .clk(clk), .rst(rst[1]), .start(start[1]), .a_out(a_o[1]), .b_out(b_o[1]),
      .and_in(gi[1][0]), .or_in(gi[1][1]), .not_in(gi[1][2]), .nand_in(gi[1][3]),
      .nor_in(gi[1][4]), .xor_in(gi[1][5]), .xnor_in(gi[1][6]),
      .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_mask(em[1]),
      .err_count(ec1), .fail_vec(fv[1]), .fail_valid(fvld[1]));

   logic_gates_bist_checker #(.SETTLE_CYCLES(0), .ERR_CNT_W(5)) u_dut2 (
      .clk(clk), .rst(rst[2]), .start(start[2]), .a_out(a_o[2]), .b_out(b_o[2]),
      .and_in(gi[2][0]), .or_in(gi[2][1]), .not_in(gi[2][2]), .nand_in(gi[2][3]),
      .nor_in(gi[2][4]), .xor_in(gi[2][5]), .xnor_in(gi[2][6]),
      .busy(busy[2]), .done(done[2]), .pass(pass[2]), .err_mask(em[2]),
      .err_count(ec2), .fail_vec(fv[2]), .fail_valid(fvld[2]));

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference: evaluate each vector's truth table against the faulted unit.
   task automatic model(input logic [6:0] iv, input logic [6:0] sk, input int cw,
                        output logic [6:0] m_mask, output int m_cnt,
                        output logic [1:0] m_fv, output logic m_fvld);
      int total;
      m_mask = 7'd0; total = 0; m_fv = 2'd0; m_fvld = 1'b0;
      for (int v = 0; v < 4; v++) begin
         int a, b;
         logic [6:0] gold, seen, m;
         a = v / 2; b = v % 2;
         gold[0] = (a && b);   gold[1] = (a || b);   gold[2] = (a == 0);
         gold[3] = !(a && b);  gold[4] = !(a || b);  gold[5] = (a != b);
         gold[6] = (a == b);
         for (int i = 0; i < 7; i++) seen[i] = sk[i] ? 1'b0 : (gold[i] ^ iv[i]);
         m = gold ^ seen;
         m_mask |= m;
         total += $countones(m);
         if (m != 0 && !m_fvld) begin
            m_fv = v[1:0];
            m_fvld = 1'b1;
         end
      end
      m_cnt = (total > (1 << cw) - 1) ? (1 << cw) - 1 : total;
   endtask

   task automatic run_check(input int k, input int cw, input int exp_edges,
                            input int repulse, input string tag);
      logic [6:0] m_mask;
      int m_cnt, edges, busy_bad;
      logic [1:0] m_fv, ab, prev;
      logic m_fvld;
      logic [1:0] q[$];
      model(inv[k], stk[k], cw, m_mask, m_cnt, m_fv, m_fvld);
      start[k] = 1'b1;
      @(posedge clk); #1;
      start[k] = 1'b0;
      check_val({tag, "_busy_start"}, busy[k], 1);
      edges = 0; busy_bad = 0; prev = 2'd0;
      while (!done[k] && edges < 60) begin
         if (edges + 1 == repulse) start[k] = 1'b1;
         @(posedge clk); #1;
         start[k] = 1'b0;
         edges++;
         ab = {a_o[k], b_o[k]};
         if (ab != prev) begin
            q.push_back(ab);
            prev = ab;
         end
         if (!done[k] && !busy[k]) busy_bad++;
      end
      check_val({tag, "_done_edge"}, edges, exp_edges);
      check_val({tag, "_busy_gap"}, busy_bad, 0);
      check_val({tag, "_busy_end"}, busy[k], 0);
      check_val({tag, "_ab_count"}, q.size(), 4);
      if (q.size() == 4) check_val({tag, "_ab_seq"}, {q[0], q[1], q[2], q[3]}, 8'h6C);
      check_val({tag, "_err_mask"}, em[k], m_mask);
      check_val({tag, "_err_count"}, ec[k], m_cnt);
      check_val({tag, "_fail_valid"}, fvld[k], m_fvld);
      check_val({tag, "_fail_vec"}, fv[k], m_fv);
      check_val({tag, "_pass"}, pass[k], (m_mask == 7'd0));
   endtask

   task automatic check_idle(input int k, input string tag);
      check_val({tag, "_outs"},
                {busy[k], done[k], pass[k], fvld[k], a_o[k], b_o[k], em[k], ec[k], fv[k]}, 0);
   endtask

   initial begin
      int dcnt;
      rst = 3'b111; start = 3'b000;
      for (int i = 0; i < 3; i++) begin
         inv[i] = 7'd0;
         stk[i] = 7'd0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) check_idle(i, "reset");
      rst = 3'b000;
      @(posedge clk); #1;

      run_check(0, 5, 17, 0, "golden");
      @(posedge clk); #1;
      check_val("golden_done_fall", done[0], 0);

      stk[0] = 7'b0000001;
      run_check(0, 5, 17, 0, "and_stuck0");
      stk[0] = 7'd0; inv[0] = 7'b0100000;
      run_check(0, 5, 17, 0, "xor_inv");
      inv[0] = 7'h7F;
      run_check(0, 5, 17, 0, "all_inv_w5");
      inv[1] = 7'h7F;
      run_check(1, 2, 17, 0, "all_inv_w2");
      inv[0] = 7'd0;
      run_check(0, 5, 17, 5, "restart_ignored");
      @(posedge clk); #1;
      check_val("restart_single_done", done[0], 0);

      // Abort mid-run after the first vector has already logged errors.
      inv[0] = 7'b0100000;
      start[0] = 1'b1;
      @(posedge clk); #1;
      start[0] = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check_val("pre_abort_mask", em[0], 7'b0100000);
      rst[0] = 1'b1;
      @(posedge clk); #1;
      rst[0] = 1'b0;
      check_idle(0, "abort");
      dcnt = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (done[0] || busy[0]) dcnt++;
      end
      check_val("abort_quiet", dcnt, 0);
      inv[0] = 7'd0;
      run_check(0, 5, 17, 0, "after_abort");

      run_check(2, 5, 9, 0, "settle0_a");
      run_check(2, 5, 9, 0, "settle0_b2b");
      inv[2] = 7'b0010010; stk[2] = 7'b1000000;
      run_check(2, 5, 9, 0, "settle0_fault");

      for (int r = 0; r < 8; r++) begin
         int k;
         k = r % 3;
         inv[k] = 7'($urandom);
         stk[k] = 7'($urandom & $urandom);
         run_check(k, (k == 1) ? 2 : 5, (k == 2) ? 9 : 17, 0, $sformatf("rand%0d", r));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
